alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
- Issue/writeback stage directly upstream of the 4-bit combinational ALU (`cpu`).
- Accepts 9-bit instructions on a valid/ready handshake and reads operands from a 4x4-bit register file.
- Drives the ALU's a, b, s2, s1 and s0 inputs from a registered issue stage, then writes the ALU result back into the register file.
- Supports load-immediate, back-to-back dependency handling and an illegal-op flag.

Parameters:
NREG, 4, number of registers (fixed at 4; 2-bit register indices)
DW, 4, data width (must match the ALU width)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
instr_valid  input  1  instruction offered
instr_ready  output  1  stage can accept; transfer occurs when instr_valid && instr_ready
instr  input  9  {op[2:0], rd[1:0], ra[1:0], rb[1:0]}
alu_a  output  4  ALU operand a (registered)
alu_b  output  4  ALU operand b (registered)
alu_s2  output  1  ALU select bit 2 (registered)
alu_s1  output  1  ALU select bit 1 (registered)
alu_s0  output  1  ALU select bit 0 (registered)
alu_out  input  4  combinational ALU result for current alu_* values
wb_valid  output  1  one-cycle pulse, writeback completed
wb_rd  output  2  register written
wb_data  output  4  value written
z_flag  output  1  set if last ALU writeback == 0
err  output  1  sticky illegal-op flag

Behaviour:
- Opcodes:
  - 000 AND, 001 OR, 010 XOR, 011 NOT a.
  - 100 SUB (a-b), 101 ADD (a+b).
  - 110 LDI: rd <= {ra,rb} as a 4-bit immediate; ALU bypassed.
  - 111 illegal.
- Pipeline:
  - Cycle N: accepted instruction is decoded; ra/rb are read (with forwarding) and captured into the issue register (iss_valid=1).
  - Cycle N+1: alu_* outputs reflect the issue register. At the rising edge ending N+1, the register file is updated: rd <= alu_out for ALU ops, or the immediate for LDI.
  - Cycle N+2: wb_valid=1 with wb_rd and wb_data registered.
- Latency: acceptance to wb_valid = 2 cycles. Throughput: 1 instruction/cycle when there is no stall.
- Arithmetic: ADD/SUB wrap modulo 16; no carry out. The ALU is trusted; this block does not check alu_out.
- z_flag: updated only on an ALU-op writeback (000-101), set to (alu_out==0). Unchanged by LDI and illegal ops.
- Illegal op 111:
  - accepted, occupies the issue slot;
  - register file unchanged, no wb_valid pulse;
  - err set, and held until reset.
- alu_* outputs when iss_valid=0: hold their previous values. The ALU result is ignored.
- Dependency: if the incoming instruction's ra or rb equals the rd of the valid issue-stage instruction (LDI or ALU op), the operand takes the value being written this cycle. See Optional Feature.
- Both operand indices equal (ra==rb): both operands use the same value, forwarded if applicable.
- Write/read of the same register in the same cycle without a stage dependency: the register-file read returns the old value. Forwarding covers the only in-flight write.
- instr_ready:
  - 1 whenever out of reset and not stalled. No downstream backpressure exists.
  - Depends combinationally on instr only when ALU_FWD_EN is undefined.
- Reset (async, any time, including mid-pipeline):
  - registers r0-r3 = 0, iss_valid = 0;
  - alu_a = alu_b = 0 and s2/s1/s0 = 0;
  - wb_valid = 0, wb_rd = 0, wb_data = 0;
  - z_flag = 0, err = 0, instr_ready = 0 while reset is high.
  - The in-flight instruction is discarded with no writeback. instr_ready = 1 on the first clock after deassertion.

Optional Feature:
- Macro: ALU_FWD_EN.
- Defined:
  - the issue-stage result (alu_out or immediate) is forwarded to the decode read mux;
  - dependent back-to-back instructions issue without a stall.
- Undefined:
  - no forwarding;
  - instr_ready is driven low for one cycle when iss_valid && rd_iss is in {ra, rb} of the offered instruction;
  - the instruction is accepted the following cycle with the written value read from the register file.
- Results are identical in both builds; only cycle timing differs.

Test Plan:
1. After reset: LDI r0=0110, LDI r1=0011, then AND/OR/XOR/NOT r2 with ra=r0, rb=r1 -> wb_data 0010, 0111, 0101, 1001; z_flag=0.
2. SUB r3=r0-r1 -> 0011. ADD r3=r0+r1 -> 1001. LDI r2=1001, ADD r2=r2+r2 -> 0010 (wrap). SUB r0-r0 -> 0000 with z_flag=1.
3. Back-to-back: LDI r1=0101 immediately followed by ADD r2=r1+r1 -> wb_data 1010.
   - With ALU_FWD_EN: wb_valid pulses on consecutive cycles.
   - Without ALU_FWD_EN: instr_ready is low for 1 cycle and the pulses are 2 cycles apart.
4. Illegal op 111 between two ADDs -> no wb_valid for it, err=1 and sticky, registers unchanged, surrounding ADDs correct.
5. Assert reset while an ADD is in the issue stage:
   - no wb_valid;
   - all outputs reach their reset values immediately;
   - registers read back 0 (e.g. ADD r0=r1+r2 -> 0000, z_flag=1).
6. Continuous instr_valid for 8 independent LDIs -> instr_ready stays 1 and 8 wb_valid pulses occur on consecutive cycles, starting 2 cycles after the first accept.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback stage feeding the 4-bit combinational ALU, with a 4x4 register file.
// Optional macro ALU_FWD_EN: forward the issue-stage result instead of stalling on a dependency.
module alu_issue_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [8:0] instr,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_s2,
    output logic       alu_s1,
    output logic       alu_s0,
    input  logic [3:0] alu_out,
    output logic       wb_valid,
    output logic [1:0] wb_rd,
    output logic [3:0] wb_data,
    output logic       z_flag,
    output logic       err
);
    localparam int NREG = 4;
    localparam int DW   = 4;

    localparam logic [2:0] OP_LDI = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    logic [2:0]                dec_op_s;
    logic [1:0]                dec_rd_s;
    logic [1:0]                dec_ra_s;
    logic [1:0]                dec_rb_s;
    logic [DW-1:0]             opa_s;
    logic [DW-1:0]             opb_s;
    logic                      iss_wr_s;
    logic [DW-1:0]             iss_res_s;
    logic                      hit_a_s;
    logic                      hit_b_s;
    logic                      stall_s;
    logic                      accept_s;

    logic [NREG-1:0][DW-1:0]   rf_q, rf_d;
    logic                      iss_valid_q, iss_valid_d;
    logic [2:0]                iss_op_q, iss_op_d;
    logic [1:0]                iss_rd_q, iss_rd_d;
    logic [DW-1:0]             iss_imm_q, iss_imm_d;
    logic [DW-1:0]             alu_a_q, alu_a_d;
    logic [DW-1:0]             alu_b_q, alu_b_d;
    logic [2:0]                alu_sel_q, alu_sel_d;
    logic                      wb_valid_q, wb_valid_d;
    logic [1:0]                wb_rd_q, wb_rd_d;
    logic [DW-1:0]             wb_data_q, wb_data_d;
    logic                      z_q, z_d;
    logic                      err_q, err_d;

    assign dec_op_s = instr[8:6];
    assign dec_rd_s = instr[5:4];
    assign dec_ra_s = instr[3:2];
    assign dec_rb_s = instr[1:0];

    // Only LDI and ALU ops in the issue slot produce a write at the next edge.
    assign iss_wr_s  = iss_valid_q && (iss_op_q != OP_ILL);
    assign iss_res_s = (iss_op_q == OP_LDI) ? iss_imm_q : alu_out;
    assign hit_a_s   = iss_wr_s && (iss_rd_q == dec_ra_s);
    assign hit_b_s   = iss_wr_s && (iss_rd_q == dec_rb_s);

`ifdef ALU_FWD_EN
    assign stall_s = 1'b0;
    assign opa_s   = hit_a_s ? iss_res_s : rf_q[dec_ra_s];
    assign opb_s   = hit_b_s ? iss_res_s : rf_q[dec_rb_s];
`else
    // LDI and illegal ops carry no register operands, so they never wait.
    assign stall_s = (dec_op_s[2:1] != 2'b11) && (hit_a_s || hit_b_s);
    assign opa_s   = rf_q[dec_ra_s];
    assign opb_s   = rf_q[dec_rb_s];
`endif

    assign instr_ready = !reset && !stall_s;
    assign accept_s    = instr_valid && instr_ready;

    // Next-state logic for the issue, register-file and writeback stages.
    always_comb begin
        iss_valid_d = 1'b0;
        iss_op_d    = iss_op_q;
        iss_rd_d    = iss_rd_q;
        iss_imm_d   = iss_imm_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rf_d        = rf_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        z_d         = z_q;
        err_d       = err_q;

        if (accept_s) begin
            iss_valid_d = 1'b1;
            iss_op_d    = dec_op_s;
            iss_rd_d    = dec_rd_s;
            iss_imm_d   = {dec_ra_s, dec_rb_s};
            if (dec_op_s[2:1] != 2'b11) begin
                alu_a_d   = opa_s;
                alu_b_d   = opb_s;
                alu_sel_d = dec_op_s;
            end else begin
                alu_sel_d = alu_sel_q;
            end
            if (dec_op_s == OP_ILL) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
        end else begin
            iss_valid_d = 1'b0;
        end

        if (iss_wr_s) begin
            rf_d[iss_rd_q] = iss_res_s;
            wb_valid_d     = 1'b1;
            wb_rd_d        = iss_rd_q;
            wb_data_d      = iss_res_s;
            if (iss_op_q != OP_LDI) begin
                z_d = (alu_out == 4'd0);
            end else begin
                z_d = z_q;
            end
        end else begin
            wb_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any in-flight instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_q        <= '0;
            iss_valid_q <= 1'b0;
            iss_op_q    <= 3'd0;
            iss_rd_q    <= 2'd0;
            iss_imm_q   <= 4'd0;
            alu_a_q     <= 4'd0;
            alu_b_q     <= 4'd0;
            alu_sel_q   <= 3'd0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= 2'd0;
            wb_data_q   <= 4'd0;
            z_q         <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            rf_q        <= rf_d;
            iss_valid_q <= iss_valid_d;
            iss_op_q    <= iss_op_d;
            iss_rd_q    <= iss_rd_d;
            iss_imm_q   <= iss_imm_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            z_q         <= z_d;
            err_q       <= err_d;
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_s2   = alu_sel_q[2];
    assign alu_s1   = alu_sel_q[1];
    assign alu_s0   = alu_sel_q[0];
    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign z_flag   = z_q;
    assign err      = err_q;

endmodule
